// File: rtl/rsa_run_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rsa_run_sequencer_if
// Description : Core handshake, data-memory read port and gpio pixel stream
//               shared between the run sequencer (master) and the core,
//               memory and board side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rsa_run_sequencer_if #(
   parameter int ADDR_W = 18
) ();
   logic              core_start;
   logic              core_sel;
   logic [3:0]        core_sector;
   logic              core_done;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic [7:0]        gpio;
   logic              gpio_valid;

   modport master (
      output core_start, core_sel, core_sector,
      output mem_rd_en, mem_addr,
      output gpio, gpio_valid,
      input  core_done, mem_rdata
   );

   modport slave (
      input  core_start, core_sel, core_sector,
      input  mem_rd_en, mem_addr,
      input  gpio, gpio_valid,
      output core_done, mem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/rsa_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rsa_run_sequencer
// Description : Run controller for the ASIP image-processing system. Dumps
//               the input image onto gpio after reset, arms the core on a
//               start edge, waits for its done flag (with timeout) and then
//               dumps the result region onto gpio.
//               Optional macro RSA_SEQ_CHECKSUM_EN adds a 16-bit wrap-around
//               sum of the result bytes on the checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_run_sequencer #(
   parameter int ADDR_W       = 18,
   parameter int IN_PIXELS    = 160000,
   parameter int OUT_BASE     = 160000,
   parameter int OUT_PIXELS_A = 40000,
   parameter int OUT_PIXELS_B = 88804,
   parameter int RD_LAT       = 1,
   parameter int TIMEOUT      = 2**24
) (
   input  logic                clk,
   input  logic                rst,            // active-low, asynchronous
   input  logic                start,
   input  logic                selected,
   input  logic [3:0]          sector_select,
   rsa_run_sequencer_if.master bus,
   output logic                busy,
   output logic                error,
   output logic [15:0]         checksum
);

   // The RUN timeout may exceed the address range, so it gets its own width.
   localparam int                c_to_w       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_to_w-1:0] c_to_last    = c_to_w'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] c_in_last    = ADDR_W'(IN_PIXELS - 1);
   localparam logic [ADDR_W-1:0] c_outa_last  = ADDR_W'(OUT_PIXELS_A - 1);
   localparam logic [ADDR_W-1:0] c_outb_last  = ADDR_W'(OUT_PIXELS_B - 1);
   localparam logic [ADDR_W-1:0] c_out_base   = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] c_drain_last = ADDR_W'(RD_LAT - 1);

   typedef enum logic [2:0] {
      ST_BOOT     = 3'd0,   // reset value: DUMP_IN pending
      ST_DUMP_IN  = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_IDLE     = 3'd3,
      ST_ARM      = 3'd4,
      ST_RUN      = 3'd5,
      ST_DUMP_OUT = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   state_t              r_state, w_state_n;
   logic [ADDR_W-1:0]   r_cnt, w_cnt_n;
   logic [c_to_w-1:0]   r_timer, w_timer_n;
   logic                r_ret_done, w_ret_done_n;
   logic                r_error, w_error_n;
   logic                r_start_q, r_done_q;
   logic                w_start_edge, w_done_edge;
   logic                w_accept;
   logic                r_core_sel;
   logic [3:0]          r_core_sector;
   logic                w_core_start;
   logic                w_rd_en;
   logic [ADDR_W-1:0]   w_addr;
   logic [ADDR_W-1:0]   w_out_last;
   logic                w_pipe_valid;
   logic [7:0]          w_gpio;
   logic [7:0]          r_gpio_hold;

`ifdef RSA_SEQ_CHECKSUM_EN
   // Read pipeline carries {result-dump flag, valid}.
   localparam int c_pw = 2;
   logic          w_rd_out;
   logic          w_pipe_out;
   logic [15:0]   r_checksum;
`else
   localparam int c_pw = 1;
`endif

   logic [c_pw-1:0] w_stage_in, w_stage_out;

   assign w_start_edge = start & ~r_start_q;
   assign w_done_edge  = bus.core_done & ~r_done_q;
   assign w_out_last   = r_core_sel ? c_outb_last : c_outa_last;

   // Register start and core_done once for rising-edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_start_q <= 1'b0;
         r_done_q  <= 1'b0;
      end else begin
         r_start_q <= start;
         r_done_q  <= bus.core_done;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_state_n;
      end
   end

   // Next-state, counter updates and per-state outputs.
   always_comb begin
      w_state_n    = r_state;
      w_cnt_n      = r_cnt;
      w_timer_n    = r_timer;
      w_ret_done_n = r_ret_done;
      w_error_n    = r_error;
      w_accept     = 1'b0;
      w_core_start = 1'b0;
      w_rd_en      = 1'b0;
      w_addr       = '0;
      case (r_state)
         ST_BOOT: begin
            w_state_n = ST_DUMP_IN;
            w_cnt_n   = '0;
         end
         ST_DUMP_IN: begin
            w_rd_en = 1'b1;
            w_addr  = r_cnt;
            if (r_cnt == c_in_last) begin
               w_state_n    = ST_DRAIN;
               w_cnt_n      = '0;
               w_ret_done_n = 1'b0;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         ST_DRAIN: begin
            // Reads already issued are still in flight for RD_LAT cycles.
            if (r_cnt == c_drain_last) begin
               w_state_n = r_ret_done ? ST_DONE : ST_IDLE;
               w_cnt_n   = '0;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         ST_IDLE: begin
            if (w_start_edge) begin
               w_accept  = 1'b1;
               w_error_n = 1'b0;
               w_state_n = ST_ARM;
            end
         end
         ST_ARM: begin
            w_core_start = 1'b1;
            w_timer_n    = '0;
            w_state_n    = ST_RUN;
         end
         ST_RUN: begin
            // A done edge takes priority over a simultaneous timeout.
            if (w_done_edge) begin
               w_state_n = ST_DUMP_OUT;
               w_cnt_n   = '0;
            end else if (r_timer == c_to_last) begin
               w_error_n = 1'b1;
               w_state_n = ST_IDLE;
            end else begin
               w_timer_n = r_timer + 1'b1;
            end
         end
         ST_DUMP_OUT: begin
            w_rd_en = 1'b1;
            w_addr  = c_out_base + r_cnt;
            if (r_cnt == w_out_last) begin
               w_state_n    = ST_DRAIN;
               w_cnt_n      = '0;
               w_ret_done_n = 1'b1;
            end else begin
               w_cnt_n = r_cnt + 1'b1;
            end
         end
         ST_DONE: begin
            w_state_n = ST_IDLE;
         end
         default: begin
            w_state_n = ST_BOOT;
         end
      endcase
   end

   // Counters, sticky error and run configuration latched on an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt         <= '0;
         r_timer       <= '0;
         r_ret_done    <= 1'b0;
         r_error       <= 1'b0;
         r_core_sel    <= 1'b0;
         r_core_sector <= 4'h0;
      end else begin
         r_cnt      <= w_cnt_n;
         r_timer    <= w_timer_n;
         r_ret_done <= w_ret_done_n;
         r_error    <= w_error_n;
         if (w_accept) begin
            r_core_sel    <= selected;
            r_core_sector <= sector_select;
         end
      end
   end

`ifdef RSA_SEQ_CHECKSUM_EN
   assign w_rd_out   = (r_state == ST_DUMP_OUT);
   assign w_stage_in = {w_rd_out, w_rd_en};
   assign w_pipe_out = w_stage_out[1];
`else
   assign w_stage_in = w_rd_en;
`endif
   assign w_pipe_valid = w_stage_out[0];

   // Valid (and dump-kind) delay line matching the memory read latency.
   generate
      if (RD_LAT <= 1) begin : g_lat1
         logic [c_pw-1:0] r_p0;
         // Single-stage read pipeline.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_p0 <= '0;
            end else begin
               r_p0 <= w_stage_in;
            end
         end
         assign w_stage_out = r_p0;
      end else begin : g_lat2
         logic [c_pw-1:0] r_p0, r_p1;
         // Two-stage read pipeline.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_p0 <= '0;
               r_p1 <= '0;
            end else begin
               r_p0 <= w_stage_in;
               r_p1 <= r_p0;
            end
         end
         assign w_stage_out = r_p1;
      end
   endgenerate

   // gpio shows read data while valid and holds the last pixel otherwise.
   assign w_gpio = w_pipe_valid ? bus.mem_rdata : r_gpio_hold;

   // Hold register for the last streamed pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_gpio_hold <= 8'h00;
      end else begin
         r_gpio_hold <= w_gpio;
      end
   end

`ifdef RSA_SEQ_CHECKSUM_EN
   // Wrap-around sum of result bytes; restarted by each accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_checksum <= 16'h0000;
      end else if (w_accept) begin
         r_checksum <= 16'h0000;
      end else if (w_pipe_valid && w_pipe_out) begin
         r_checksum <= r_checksum + {8'h00, w_gpio};
      end
   end
   assign checksum = r_checksum;
`else
   assign checksum = 16'h0000;
`endif

   assign bus.core_start  = w_core_start;
   assign bus.core_sel    = r_core_sel;
   assign bus.core_sector = r_core_sector;
   assign bus.mem_rd_en   = w_rd_en;
   assign bus.mem_addr    = w_addr;
   assign bus.gpio        = w_gpio;
   assign bus.gpio_valid  = w_pipe_valid;
   assign busy            = (r_state != ST_IDLE) && (r_state != ST_BOOT);
   assign error           = r_error;

endmodule
`default_nettype wire

// File: tb/tb_rsa_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_run_sequencer
// Description : Scoreboard bench for rsa_run_sequencer with a small image
//               (16 input bytes, result region at 16 of 4 or 9 bytes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_run_sequencer;

   localparam int ADDR_W = 18;

`ifdef RSA_SEQ_CHECKSUM_EN
   localparam int c_ck_a = 70;    // 16+17+18+19
   localparam int c_ck_b = 180;   // 16+..+24
`else
   localparam int c_ck_a = 0;
   localparam int c_ck_b = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        selected = 1'b0;
   logic [3:0]  sector_select = 4'h0;
   logic        busy;
   logic        error;
   logic [15:0] checksum;

   logic [7:0]  mem [0:63];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          run_len = 0;
   int          cs_count = 0;
   int          exp_q[$];
   int          run_q[$];

   rsa_run_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   rsa_run_sequencer #(
      .ADDR_W(ADDR_W), .IN_PIXELS(16), .OUT_BASE(16), .OUT_PIXELS_A(4),
      .OUT_PIXELS_B(9), .RD_LAT(1), .TIMEOUT(64)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .selected(selected),
      .sector_select(sector_select), .bus(bus),
      .busy(busy), .error(error), .checksum(checksum)
   );

   always #5 clk = ~clk;

   // Memory with one cycle of read latency, mem[a] = a.
   initial begin
      bus.core_done = 1'b0;
      bus.mem_rdata = 8'h00;
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
   end
   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[5:0]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every valid pixel, records run lengths
   // and counts core_start pulses.
   always @(negedge clk) begin
      if (bus.core_start === 1'b1) cs_count++;
      if (bus.gpio_valid === 1'b1) begin
         if (exp_q.size() == 0) check("stray_pixel", 32'(bus.gpio), 32'hFFFF_FFFF);
         else check("gpio", 32'(bus.gpio), 32'(exp_q.pop_front()));
         run_len++;
      end else if (run_len != 0) begin
         run_q.push_back(run_len);
         run_len = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_range(input int first, input int count);
      for (int i = 0; i < count; i++) exp_q.push_back(first + i);
   endtask

   task automatic check_run(input string name, input int exp);
      #1;
      if (run_q.size() == 0) check(name, 0, 32'(exp));
      else check(name, 32'(run_q.pop_front()), 32'(exp));
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 0);
   endtask

   // Clean start edge in IDLE; returns one cycle into RUN. Inputs are
   // scrambled after acceptance to show the latched copies are held.
   task automatic do_start(input logic sel, input logic [3:0] sec);
      start = 1'b0;
      tick();
      start = 1'b1;
      selected = sel;
      sector_select = sec;
      tick();
      @(negedge clk);
      check("arm_core_start", 32'(bus.core_start), 1);
      check("arm_error_clear", 32'(error), 0);
      selected = ~sel;
      sector_select = ~sec;
      tick();
      @(negedge clk);
      check("run_core_start_low", 32'(bus.core_start), 0);
      check("core_sel_held", 32'(bus.core_sel), 32'(sel));
      check("core_sector_held", 32'(bus.core_sector), 32'(sec));
   endtask

   task automatic done_edge_run(input int first, input int count);
      push_range(first, count);
      tick();
      bus.core_done = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_rd_en", 32'(bus.mem_rd_en), 0);
      check("rst_valid", 32'(bus.gpio_valid), 0);
      check("rst_gpio", 32'(bus.gpio), 0);
      check("rst_error", 32'(error), 0);
      check("rst_checksum", 32'(checksum), 0);

      // Input dump after release.
      push_range(0, 16);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("in_rd_en", 32'(bus.mem_rd_en), 1);
      check("in_addr0", 32'(bus.mem_addr), 0);
      check("in_valid_late", 32'(bus.gpio_valid), 0);
      @(negedge clk);
      check("in_valid_start", 32'(bus.gpio_valid), 1);
      repeat (15) @(negedge clk);
      check("drain_busy", 32'(busy), 1);
      check("drain_rd_en", 32'(bus.mem_rd_en), 0);
      check("drain_valid", 32'(bus.gpio_valid), 1);
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check_run("in_run_len", 16);

      // Run with selected=0, sector 5.
      cs_count = 0;
      do_start(1'b0, 4'b0101);
      repeat (9) tick();
      done_edge_run(16, 4);
      wait_idle("run_a_idle", 40);
      bus.core_done = 1'b0;
      check_run("run_a_len", 4);
      check("run_a_cs", 32'(cs_count), 1);
      check("run_a_checksum", 32'(checksum), c_ck_a);

      // Run with selected=1; start edges inside RUN are ignored.
      cs_count = 0;
      do_start(1'b1, 4'b1100);
      tick(); start = 1'b0;
      tick(); start = 1'b1;
      tick(); start = 1'b0;
      tick(); start = 1'b1;
      repeat (4) tick();
      done_edge_run(16, 9);
      wait_idle("run_b_idle", 40);
      bus.core_done = 1'b0;
      check_run("run_b_len", 9);
      check("run_b_cs", 32'(cs_count), 1);
      check("run_b_checksum", 32'(checksum), c_ck_b);

      // Timeout: 64 RUN cycles with no done edge.
      cs_count = 0;
      do_start(1'b0, 4'h2);
      repeat (63) @(negedge clk);
      check("to_busy_last", 32'(busy), 1);
      check("to_error_early", 32'(error), 0);
      @(negedge clk);
      check("to_idle", 32'(busy), 0);
      check("to_error", 32'(error), 1);

      // Recovery run; done level high on entry is not an edge.
      bus.core_done = 1'b1;
      do_start(1'b0, 4'h6);
      repeat (5) tick();
      @(negedge clk);
      check("done_level_busy", 32'(busy), 1);
      check("done_level_no_rd", 32'(bus.mem_rd_en), 0);
      bus.core_done = 1'b0;
      done_edge_run(16, 4);
      wait_idle("recov_idle", 40);
      bus.core_done = 1'b0;
      check_run("recov_len", 4);
      check("recov_error", 32'(error), 0);
      check("recov_cs", 32'(cs_count), 2);

      // Reset during the result dump at byte 2.
      do_start(1'b1, 4'hA);
      repeat (2) tick();
      done_edge_run(16, 9);
      begin
         int n = 0;
         @(negedge clk);
         while (!(bus.gpio_valid === 1'b1 && bus.gpio == 8'd18) && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("reach_byte2", 32'(bus.gpio), 18);
      end
      #2 rst = 1'b0;
      start = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.gpio_valid), 0);
      check("mid_rst_gpio", 32'(bus.gpio), 0);
      check("mid_rst_rd_en", 32'(bus.mem_rd_en), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_sel", 32'(bus.core_sel), 0);
      check("mid_rst_sector", 32'(bus.core_sector), 0);
      bus.core_done = 1'b0;
      @(negedge clk);
      check_run("aborted_len", 3);
      exp_q.delete();

      // Restarted input dump with start held high throughout.
      push_range(0, 16);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("re_addr0", 32'(bus.mem_addr), 0);
      check("re_rd_en", 32'(bus.mem_rd_en), 1);
      wait_idle("re_idle", 40);
      check_run("re_len", 16);
      cs_count = 0;
      repeat (8) @(negedge clk);
      check("held_start_busy", 32'(busy), 0);
      check("held_start_cs", 32'(cs_count), 0);

      // Fresh edge is accepted.
      do_start(1'b0, 4'h3);
      repeat (3) tick();
      done_edge_run(16, 4);
      wait_idle("final_idle", 40);
      bus.core_done = 1'b0;
      check_run("final_len", 4);
      check("final_cs", 32'(cs_count), 1);
      check("leftover", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rsa_run_sequencer.md
Name: rsa_run_sequencer

Overview:
- Top-level run controller for the ASIP image-processing system.
- After reset it streams the input image from shared data memory onto gpio.
- It then arms the core on a start edge and waits for the core's done flag (reg15).
- It then streams the result region onto gpio; the length depends on the selected algorithm.
- Sits between the board I/O (buttons/switches) and the core plus data-memory read port; it replaces bench-side sequencing.

Parameters:
- ADDR_W, 18, data-memory address width.
- IN_PIXELS, 160000, input image bytes dumped after reset.
- OUT_BASE, 160000, first address of the result region.
- OUT_PIXELS_A, 40000, result bytes when selected=0.
- OUT_PIXELS_B, 88804, result bytes when selected=1.
- RD_LAT, 1, memory read latency in cycles (1 or 2).
- TIMEOUT, 2**24, maximum RUN cycles before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  level from button; the rising edge is used.
- selected  in  1  algorithm select; sampled on the accepted start edge.
- sector_select  in  4  sector choice; sampled on the accepted start edge.
- core_done  in  1  core completion flag (reg15); the rising edge is used.
- core_start  out  1  one-cycle start pulse to the core.
- core_sel  out  1  latched selected.
- core_sector  out  4  latched sector_select.
- mem_rd_en  out  1  read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  8  read data, valid RD_LAT cycles after mem_rd_en.
- gpio  out  8  streamed pixel.
- gpio_valid  out  1  gpio holds a valid pixel this cycle.
- busy  out  1  high in every state except IDLE.
- error  out  1  sticky RUN timeout flag.
- checksum  out  16  see Optional Feature.

Behaviour:
- Reset values (while rst=0): state DUMP_IN pending, all outputs 0, counters 0, edge-detect registers 0.
- Edge detect: start and core_done are each registered once. An edge means prev=0 and now=1.
- DUMP_IN, entered on the first clk after reset release:
  - mem_rd_en=1 each cycle; mem_addr=0..IN_PIXELS-1.
  - gpio/gpio_valid follow the read pipeline with exactly RD_LAT cycles delay.
  - After the last address is issued, go to DRAIN.
- DRAIN: hold mem_rd_en=0 for RD_LAT cycles until the pipeline empties, then go to the return state (IDLE after DUMP_IN, DONE after DUMP_OUT).
- IDLE: busy=0. On a start edge:
  - latch selected and sector_select into core_sel and core_sector;
  - clear error and checksum;
  - go to ARM.
  Start edges in any other state are ignored and never queued.
- ARM: core_start=1 for exactly one cycle, then go to RUN with the timeout counter at 0.
- RUN:
  - Count cycles.
  - A core_done edge goes to DUMP_OUT.
  - If the counter reaches TIMEOUT-1 with no edge: set error=1 and go to IDLE.
  - A done edge in the same cycle as the timeout wins; no error is set.
  - A core_done level already high on entry is not an edge.
- DUMP_OUT:
  - N = OUT_PIXELS_A if core_sel=0, else OUT_PIXELS_B.
  - mem_addr runs OUT_BASE..OUT_BASE+N-1, one address per cycle, no gaps.
  - Then DRAIN, then DONE.
- DONE: one cycle, then IDLE.
- Stream rules:
  - gpio is updated only when gpio_valid=1; it holds its last value otherwise.
  - gpio_valid is contiguous for exactly IN_PIXELS or N cycles per dump.
- Counters are ADDR_W bits wide. Address arithmetic wraps modulo 2**ADDR_W; parameters are chosen so no wrap occurs.
- Reset asserted mid-operation aborts immediately to reset values. Release restarts DUMP_IN.
- core_sel and core_sector stay stable from ARM through DONE.

Optional Feature:
- Macro: RSA_SEQ_CHECKSUM_EN.
- When defined: checksum is a 16-bit wrap-around sum of every gpio byte with gpio_valid=1 during DUMP_OUT. It is cleared on the accepted start edge and is final when DONE is entered.
- When undefined: checksum is tied to 0 and no adder is built.

Test Plan (IN_PIXELS=16, OUT_BASE=16, OUT_PIXELS_A=4, OUT_PIXELS_B=9, RD_LAT=1, TIMEOUT=64; memory preloaded with mem[a]=a):
- Release reset -> gpio_valid high for exactly 16 consecutive cycles, starting 2 cycles after release, with gpio=0..15; busy drops after the drain cycle.
- Start edge with selected=0, sector_select=4'b0101 -> core_start pulses one cycle; core_sector=5 is held; a core_done edge 10 cycles later produces 4 valid bytes 16,17,18,19, then busy=0.
- Same with selected=1 -> 9 valid bytes 16..24. With RSA_SEQ_CHECKSUM_EN defined, checksum=180.
- Start held high, or pulsed, during DUMP_IN and RUN -> no extra core_start; only an edge in IDLE is accepted.
- No core_done for 64 cycles -> error=1 and state IDLE. The next start edge clears error and a normal run completes.
- Reset asserted during DUMP_OUT at byte 2 -> all outputs 0 immediately; after release, DUMP_IN restarts at address 0.
